// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit-side blocks.
// Line locking in uart_tx_arbiter is enabled by UART_TX_ARB_LINE_LOCK_EN.
package uart_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } arb_state_t;

  localparam logic [7:0] UART_EOL = 8'h0A;
  localparam int unsigned UART_LOCK_TIMEOUT = 1023;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request after last_grant, wrapping.
module rr_picker #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic                 any,
  output logic [$clog2(N)-1:0] pick
);

  localparam int unsigned IdW = $clog2(N);

  int unsigned idx;

  always_comb begin
    any  = 1'b0;
    pick = '0;
    idx  = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (int'(last_grant) + i) % N;
      if (!any && req[idx]) begin
        any  = 1'b1;
        pick = IdW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART transmit write port among NUM_REQ byte producers.
// Define UART_TX_ARB_LINE_LOCK_EN to hold the port for one requester until it sends EOL_BYTE.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned LOCK_TIMEOUT = UART_LOCK_TIMEOUT,
  parameter logic [7:0]  EOL_BYTE     = UART_EOL
) (
  input  logic                       cpu_clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       uart_w_enable,
  output logic [7:0]                 uart_w_data,
  input  logic                       uart_w_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       locked
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || LOCK_TIMEOUT < 1 || $bits(EOL_BYTE) != 8) begin : g_bad_cfg
    $error("uart_tx_arbiter: illegal parameter combination");
  end

  logic           r_out_valid;
  logic [7:0]     r_out_data;
  logic [IdW-1:0] r_last_grant;

  logic           w_can_load;
  logic           w_any;
  logic [IdW-1:0] w_pick;
  logic [IdW-1:0] w_sel;
  logic [IdW-1:0] w_owner;
  logic           w_is_locked;
  logic           w_load;
  logic [7:0]     w_byte;

  rr_picker #(
    .N (NUM_REQ)
  ) u_picker (
    .req        (req_valid),
    .last_grant (r_last_grant),
    .any        (w_any),
    .pick       (w_pick)
  );

  assign w_can_load = !r_out_valid || uart_w_ready;

  always_comb begin
    req_ready = '0;
    w_sel     = w_pick;
    if (w_is_locked) begin
      // Owner keeps the port even while idle; everyone else stalls.
      w_sel              = w_owner;
      req_ready[w_owner] = w_can_load && req_valid[w_owner];
    end else if (w_any) begin
      req_ready[w_pick] = w_can_load;
    end
    if (!rst_n) req_ready = '0;
  end

  assign w_load = |(req_valid & req_ready);

  always_comb begin
    w_byte = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_sel == IdW'(i)) w_byte = req_data[8*i +: 8];
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_last_grant <= IdW'(NUM_REQ - 1);
    end else if (w_load) begin
      r_out_valid  <= 1'b1;
      r_out_data   <= w_byte;
      r_last_grant <= w_sel;
    end else if (r_out_valid && uart_w_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign uart_w_enable = r_out_valid;
  assign uart_w_data   = r_out_data;
  assign grant_id      = r_last_grant;

`ifdef UART_TX_ARB_LINE_LOCK_EN
  localparam int unsigned CntW = $clog2(LOCK_TIMEOUT + 1);

  arb_state_t      r_state, w_state_nxt;
  logic [IdW-1:0]  r_owner, w_owner_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge cpu_clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_owner <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_load && w_byte != EOL_BYTE) begin
          w_state_nxt = StLocked;
          w_owner_nxt = w_sel;
          w_cnt_nxt   = '0;
        end
      end
      StLocked: begin
        if (w_load) begin
          if (w_byte == EOL_BYTE) w_state_nxt = StIdle;
          else                    w_cnt_nxt   = '0;
        end else if (r_cnt == CntW'(LOCK_TIMEOUT)) begin
          w_state_nxt = StIdle;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_is_locked = (r_state == StLocked);
  assign w_owner     = r_owner;
`else
  assign w_is_locked = 1'b0;
  assign w_owner     = '0;
`endif

  assign locked = w_is_locked;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with three requesters and LOCK_TIMEOUT=4.
// Lock-specific steps run only when UART_TX_ARB_LINE_LOCK_EN is defined.
module tb_uart_tx_arbiter;

`ifdef UART_TX_ARB_LINE_LOCK_EN
  localparam logic LockEn = 1'b1;
`else
  localparam logic LockEn = 1'b0;
`endif

  logic        cpu_clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [23:0] req_data;
  logic [2:0]  req_ready;
  logic        uart_w_enable;
  logic [7:0]  uart_w_data;
  logic        uart_w_ready;
  logic [1:0]  grant_id;
  logic        locked;

  int errors = 0;
  int checks = 0;

  uart_tx_arbiter #(
    .NUM_REQ      (3),
    .LOCK_TIMEOUT (4),
    .EOL_BYTE     (8'h0A)
  ) dut (
    .cpu_clk       (cpu_clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .uart_w_enable (uart_w_enable),
    .uart_w_data   (uart_w_data),
    .uart_w_ready  (uart_w_ready),
    .grant_id      (grant_id),
    .locked        (locked)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    uart_w_ready = 1'b1;

    // Reset state, with requests asserted during reset.
    tick();
    req_valid = 3'b111;
    tick();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_enable", 32'(uart_w_enable), 32'h0);
    chk("rst_grant", 32'(grant_id), 32'h2);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_data", 32'(uart_w_data), 32'h0);
    req_valid = '0;
    rst_n     = 1'b1;

    // Single byte from req0.
    req_valid = 3'b001;
    req_data  = 24'h000041;
    #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    chk("single_enable", 32'(uart_w_enable), 32'h1);
    chk("single_data", 32'(uart_w_data), 32'h41);
    chk("single_grant", 32'(grant_id), 32'h0);
    chk("single_locked", 32'(locked), 32'(LockEn));
    tick();
    chk("single_drained", 32'(uart_w_enable), 32'h0);

    // Backpressure: 0x55 held for five stalled cycles while req1 waits.
    do_reset();
    req_valid = 3'b001;
    req_data  = 24'h000055;
    tick();
    uart_w_ready = 1'b0;
    req_valid    = 3'b010;
    req_data     = 24'h006600;
    #1;
    chk("bp_ready0", 32'(req_ready), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_data", 32'(uart_w_data), 32'h55);
      chk("bp_enable", 32'(uart_w_enable), 32'h1);
      chk("bp_ready", 32'(req_ready), 32'h0);
    end
    // Any lock from 0x55 has timed out by now, so req1 is eligible in both builds.
    uart_w_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    chk("bp_next_data", 32'(uart_w_data), 32'h66);
    chk("bp_next_grant", 32'(grant_id), 32'h1);
    tick();
    chk("bp_done", 32'(uart_w_enable), 32'h0);

`ifndef UART_TX_ARB_LINE_LOCK_EN
    // Round robin with all three continuously valid: 0,1,2,0,1,2 at full rate.
    do_reset();
    req_valid = 3'b111;
    req_data  = 24'h121110;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_ready", 32'(req_ready), 32'(3'b001 << (k % 3)));
      tick();
      chk("rr_grant", 32'(grant_id), 32'(k % 3));
      chk("rr_data", 32'(uart_w_data), 32'(8'h10 + k % 3));
      chk("rr_enable", 32'(uart_w_enable), 32'h1);
    end
    req_valid = '0;
`else
    // EOL accepted while idle does not lock.
    do_reset();
    req_valid = 3'b001;
    req_data  = 24'h00000A;
    tick();
    req_valid = '0;
    chk("eol_idle_locked", 32'(locked), 32'h0);

    // Line "ab\n" from req0 with gaps; req1 always valid with 'Z'.
    do_reset();
    req_data  = 24'h005A61;
    req_valid = 3'b011;
    #1;
    chk("ll_a_ready", 32'(req_ready), 32'h1);
    tick();
    chk("ll_a_data", 32'(uart_w_data), 32'h61);
    chk("ll_a_locked", 32'(locked), 32'h1);
    req_valid = 3'b010;
    #1;
    chk("ll_gap1_ready", 32'(req_ready), 32'h0);
    tick();
    chk("ll_gap1_enable", 32'(uart_w_enable), 32'h0);
    req_data  = 24'h005A62;
    req_valid = 3'b011;
    #1;
    chk("ll_b_ready", 32'(req_ready), 32'h1);
    tick();
    chk("ll_b_data", 32'(uart_w_data), 32'h62);
    chk("ll_b_grant", 32'(grant_id), 32'h0);
    req_valid = 3'b010;
    #1;
    chk("ll_gap2_ready", 32'(req_ready), 32'h0);
    tick();
    req_data  = 24'h005A0A;
    req_valid = 3'b011;
    #1;
    chk("ll_eol_ready", 32'(req_ready), 32'h1);
    tick();
    chk("ll_eol_data", 32'(uart_w_data), 32'h0A);
    chk("ll_eol_locked", 32'(locked), 32'h0);
    req_valid = 3'b010;
    #1;
    chk("ll_req1_ready", 32'(req_ready), 32'h2);
    tick();
    chk("ll_req1_grant", 32'(grant_id), 32'h1);
    chk("ll_req1_data", 32'(uart_w_data), 32'h5A);

    // Lock timeout: req0 sends 'a' then idles; counter reaches 4, next edge unlocks.
    do_reset();
    req_data  = 24'h005A61;
    req_valid = 3'b011;
    tick();
    req_valid = 3'b010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_locked", 32'(locked), 32'h1);
      chk("to_ready", 32'(req_ready), 32'h0);
    end
    tick();
    chk("to_unlocked", 32'(locked), 32'h0);
    chk("to_req1_ready", 32'(req_ready), 32'h2);
    tick();
    chk("to_req1_grant", 32'(grant_id), 32'h1);
    req_valid = '0;
`endif

    // Reset with a held byte (and a lock in the lock build): the byte is dropped.
    do_reset();
    uart_w_ready = 1'b0;
    req_valid    = 3'b100;
    req_data     = 24'h770000;
    #1;
    chk("mid_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    chk("mid_held", 32'(uart_w_data), 32'h77);
    chk("mid_locked_pre", 32'(locked), 32'(LockEn));
    rst_n = 1'b0;
    tick();
    chk("mid_rst_locked", 32'(locked), 32'h0);
    chk("mid_rst_enable", 32'(uart_w_enable), 32'h0);
    chk("mid_rst_grant", 32'(grant_id), 32'h2);
    rst_n        = 1'b1;
    uart_w_ready = 1'b1;
    tick();
    chk("mid_not_sent", 32'(uart_w_enable), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
